flag_branch_resolver: RTL and testbench
=======================================

Name: flag_branch_resolver

Overview:
- Consumer side of the 6-bit condition-flag register: reads stored flags (with same-cycle forwarding of a flag write) and resolves conditional jumps (jt.cond / jf.cond).
- Produces the registered branch_taken pulse that clears the flag register, the PC-load target, and a multi-cycle pipeline flush.
- Sits between decode (branch requests) and fetch/PC logic.

Parameters:
- ADDR_W, 32, width of branch target address.
- FLUSH_CYCLES, 2, cycles flush is held after a taken branch (1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- br_valid  input  1  branch request valid.
- br_ready  output  1  resolver can accept a request this cycle.
- br_cond  input  3  condition select: 0 TRUE, 1 NEG, 2 ZERO, 3 NEGZERO, 4 CARRY, 5 OVERFLOW, 6-7 illegal.
- br_jt  input  1  1 = jump if flag set (jt), 0 = jump if flag clear (jf).
- br_target  input  ADDR_W  jump target.
- flags_q  input  6  stored flag register value.
- fl_in  input  6  flag value being written this cycle.
- fl_write_enable  input  1  flag write occurring this cycle.
- flags_pending  input  1  multi-cycle ALU op has an outstanding flag update.
- branch_taken  output  1  one-cycle pulse, branch resolved taken.
- pc_load  output  1  one-cycle pulse, coincident with branch_taken.
- pc_target  output  ADDR_W  target, valid while pc_load = 1.
- flush  output  1  squash younger instructions.
- cond_error  output  1  one-cycle pulse, illegal br_cond accepted.

Behaviour:
- Reset (rst = 0, async): state IDLE, flush counter 0; branch_taken, pc_load, flush, cond_error = 0; pc_target = 0; br_ready = 0 while rst asserted.
- br_ready = (state == IDLE) && !flags_pending, combinational. Accept = br_valid && br_ready.
- Effective flags at accept: fl_write_enable ? fl_in : flags_q (forwarding).
- Bit order of flags: [0] TRUE, [1] NEG, [2] ZERO, [3] NEGZERO, [4] CARRY, [5] OVERFLOW; bit = br_cond index.
- Decision: sel = flags_eff[br_cond]; take = br_jt ? sel : !sel.
- Illegal br_cond (6, 7): take = 0, cond_error pulses one cycle after accept; no flush.
- Latency: outputs registered; branch_taken/pc_load/pc_target asserted exactly 1 cycle after the accepting edge.
- States:
  - IDLE: on accept with take = 1 -> RESOLVE; otherwise stay IDLE (not-taken back-to-back at 1/cycle).
  - RESOLVE (1 cycle): branch_taken = pc_load = 1, flush = 1, counter loaded with FLUSH_CYCLES-1; -> FLUSH if FLUSH_CYCLES > 1, else IDLE.
  - FLUSH: flush = 1, counter decrements; at 0 -> IDLE.
- flush high for exactly FLUSH_CYCLES cycles starting with the branch_taken cycle; br_ready = 0 throughout.
- br_valid while flags_pending = 1: held, not accepted; request must stay stable until accepted.
- br_valid while not in IDLE: ignored (br_ready = 0).
- pc_target holds its last value when pc_load = 0.
- Reset mid-FLUSH: all outputs drop to 0 immediately (async); state IDLE after release.

Decomposition:
- Shared package: flag bit-index constants (FL_TRUE..FL_OVERFLOW), condition-code encodings, FSM state encoding.
- One natural sub-module: flag_cond_eval (combinational: flags_eff, br_cond, br_jt -> take, illegal). The same constants are shared with the ALU flag generator.

Test Plan:
- Reset release, idle: rst 0 -> 1, no br_valid -> br_ready = 1, all outputs 0, pc_target = 0.
- jt ZERO taken: flags_q = 6'b000101, br_cond = 2, br_jt = 1, target 0x100 -> next cycle branch_taken = pc_load = 1, pc_target = 0x100; flush high 2 cycles; br_ready = 0 for 2 cycles.
- jf CARRY not taken, back-to-back: flags_q[4] = 1, br_jt = 0, two requests on consecutive cycles -> both accepted; branch_taken never asserts; flush = 0.
- Forwarding: flags_q = 0, same cycle fl_write_enable = 1, fl_in = 6'b000010, jt NEG -> taken using fl_in.
- flags_pending stall: br_valid held 3 cycles with flags_pending = 1 -> br_ready = 0; accepted on the first cycle pending drops; decision one cycle later.
- Illegal cond and mid-flush reset: br_cond = 7 -> cond_error pulse, no flush. Separately, rst asserted during FLUSH -> flush = 0 at once, state IDLE.

Source files
------------

// File: rtl/flag_branch_resolver_pkg.sv
// rtl/flag_branch_resolver_pkg.sv - shared flag indices, condition codes and FSM states
// Also imported by the ALU flag generator so both agree on the bit layout.
package flag_branch_resolver_pkg;
  localparam int FL_TRUE     = 0;
  localparam int FL_NEG      = 1;
  localparam int FL_ZERO     = 2;
  localparam int FL_NEGZERO  = 3;
  localparam int FL_CARRY    = 4;
  localparam int FL_OVERFLOW = 5;
  localparam int FLAGS_W     = 6;
  localparam int FLUSH_CNT_W = 4;

  typedef enum logic [2:0] {
    COND_TRUE     = 3'd0,
    COND_NEG      = 3'd1,
    COND_ZERO     = 3'd2,
    COND_NEGZERO  = 3'd3,
    COND_CARRY    = 3'd4,
    COND_OVERFLOW = 3'd5
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_FLUSH   = 2'd2
  } state_e;
endpackage

// File: rtl/flag_branch_resolver_if.sv
// rtl/flag_branch_resolver_if.sv - branch request handshake from decode to resolver
interface flag_branch_resolver_if #(
  parameter int ADDR_W = 32
);
  logic              br_valid;
  logic              br_ready;
  logic [2:0]        br_cond;
  logic              br_jt;
  logic [ADDR_W-1:0] br_target;

  modport master (output br_valid, br_cond, br_jt, br_target, input br_ready);
  modport slave  (input br_valid, br_cond, br_jt, br_target, output br_ready);
endinterface

// File: rtl/flag_branch_resolver_cond_eval.sv
// rtl/flag_branch_resolver_cond_eval.sv - combinational jt/jf condition evaluation
module flag_cond_eval
  import flag_branch_resolver_pkg::*;
(
  input  logic [FLAGS_W-1:0] flags_eff,
  input  logic [2:0]         br_cond,
  input  logic               br_jt,
  output logic               take,
  output logic               illegal
);
  logic sel;

  always_comb begin
    sel     = 1'b0;
    illegal = 1'b0;
    case (cond_e'(br_cond))
      COND_TRUE:     sel = flags_eff[FL_TRUE];
      COND_NEG:      sel = flags_eff[FL_NEG];
      COND_ZERO:     sel = flags_eff[FL_ZERO];
      COND_NEGZERO:  sel = flags_eff[FL_NEGZERO];
      COND_CARRY:    sel = flags_eff[FL_CARRY];
      COND_OVERFLOW: sel = flags_eff[FL_OVERFLOW];
      default:       illegal = 1'b1;
    endcase
  end

  // Illegal codes never branch, regardless of jt/jf polarity.
  assign take = !illegal && (br_jt ? sel : !sel);
endmodule

// File: rtl/flag_branch_resolver.sv
// rtl/flag_branch_resolver.sv - resolves conditional jumps from forwarded flags
// Drives branch_taken/pc_load/pc_target one cycle after accept, then holds flush.
module flag_branch_resolver #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  flag_branch_resolver_if.slave     bus,
  input  logic [5:0]                flags_q,
  input  logic [5:0]                fl_in,
  input  logic                      fl_write_enable,
  input  logic                      flags_pending,
  output logic                      branch_taken,
  output logic                      pc_load,
  output logic [ADDR_W-1:0]         pc_target,
  output logic                      flush,
  output logic                      cond_error
);
  import flag_branch_resolver_pkg::*;

  state_e                 state;
  logic [FLUSH_CNT_W-1:0] cnt;
  logic [FLAGS_W-1:0]     flags_eff;
  logic                   take;
  logic                   illegal;
  logic                   accept;

  // A flag write in the same cycle as the branch wins over the stored value.
  assign flags_eff    = fl_write_enable ? fl_in : flags_q;
  assign bus.br_ready = rst && (state == ST_IDLE) && !flags_pending;
  assign accept       = bus.br_valid && bus.br_ready;

  flag_cond_eval u_cond_eval (
    .flags_eff (flags_eff),
    .br_cond   (bus.br_cond),
    .br_jt     (bus.br_jt),
    .take      (take),
    .illegal   (illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      branch_taken <= 1'b0;
      pc_load      <= 1'b0;
      pc_target    <= '0;
      flush        <= 1'b0;
      cond_error   <= 1'b0;
    end else begin
      cond_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && take) begin
            state        <= ST_RESOLVE;
            branch_taken <= 1'b1;
            pc_load      <= 1'b1;
            pc_target    <= bus.br_target;
            flush        <= 1'b1;
            cnt          <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
          end else if (accept && illegal) begin
            cond_error <= 1'b1;
          end
        end
        ST_RESOLVE: begin
          branch_taken <= 1'b0;
          pc_load      <= 1'b0;
          if (FLUSH_CYCLES > 1) begin
            state <= ST_FLUSH;
            cnt   <= cnt - 1'b1;
          end else begin
            state <= ST_IDLE;
            flush <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            flush <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          branch_taken <= 1'b0;
          pc_load      <= 1'b0;
          flush        <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_flag_branch_resolver.sv
// tb/tb_flag_branch_resolver.sv - directed self-checking bench for flag_branch_resolver
module tb_flag_branch_resolver;
  logic        clk;
  logic        rst;
  logic [5:0]  flags_q;
  logic [5:0]  fl_in;
  logic        fl_write_enable;
  logic        flags_pending;
  logic        branch_taken;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        flush;
  logic        cond_error;
  int          tests_run;
  int          tests_failed;

  flag_branch_resolver_if #(.ADDR_W(32)) bus ();

  flag_branch_resolver #(.ADDR_W(32), .FLUSH_CYCLES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .flags_q         (flags_q),
    .fl_in           (fl_in),
    .fl_write_enable (fl_write_enable),
    .flags_pending   (flags_pending),
    .branch_taken    (branch_taken),
    .pc_load         (pc_load),
    .pc_target       (pc_target),
    .flush           (flush),
    .cond_error      (cond_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests_run++; if (bus.br_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ready got %b want 0", bus.br_ready); end
    tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL rst_flush got %b want 0", flush); end
    step();
    rst = 1'b1;
    #1;
    tests_run++; if (bus.br_ready !== 1'b1) begin tests_failed++; $display("FAIL idle_ready got %b want 1", bus.br_ready); end
    step();
    tests_run++; if ({branch_taken, pc_load, flush, cond_error} !== 4'b0000) begin tests_failed++; $display("FAIL idle_outs got %b want 0000", {branch_taken, pc_load, flush, cond_error}); end
    tests_run++; if (pc_target !== 32'h0) begin tests_failed++; $display("FAIL idle_target got %h want 0", pc_target); end
  endtask

  task automatic test_jt_zero_taken();
    flags_q = 6'b000101; bus.br_cond = 3'd2; bus.br_jt = 1'b1; bus.br_target = 32'h100; bus.br_valid = 1'b1;
    #1;
    tests_run++; if (bus.br_ready !== 1'b1) begin tests_failed++; $display("FAIL jt_ready got %b want 1", bus.br_ready); end
    step();
    bus.br_valid = 1'b0;
    #1;
    tests_run++; if ({branch_taken, pc_load, flush} !== 3'b111) begin tests_failed++; $display("FAIL jt_pulse got %b want 111", {branch_taken, pc_load, flush}); end
    tests_run++; if (pc_target !== 32'h100) begin tests_failed++; $display("FAIL jt_target got %h want 100", pc_target); end
    tests_run++; if (bus.br_ready !== 1'b0) begin tests_failed++; $display("FAIL jt_busy1 got %b want 0", bus.br_ready); end
    step();
    tests_run++; if ({branch_taken, pc_load, flush} !== 3'b001) begin tests_failed++; $display("FAIL jt_flush2 got %b want 001", {branch_taken, pc_load, flush}); end
    tests_run++; if (bus.br_ready !== 1'b0) begin tests_failed++; $display("FAIL jt_busy2 got %b want 0", bus.br_ready); end
    tests_run++; if (pc_target !== 32'h100) begin tests_failed++; $display("FAIL jt_hold got %h want 100", pc_target); end
    step();
    tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL jt_flush_end got %b want 0", flush); end
    tests_run++; if (bus.br_ready !== 1'b1) begin tests_failed++; $display("FAIL jt_ready_back got %b want 1", bus.br_ready); end
  endtask

  task automatic test_back_to_back();
    flags_q = 6'b010000; bus.br_cond = 3'd4; bus.br_jt = 1'b0; bus.br_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.br_target = 32'h500 + i;
      #1;
      tests_run++; if (bus.br_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready%0d got %b want 1", i, bus.br_ready); end
      step();
      tests_run++; if ({branch_taken, pc_load, flush} !== 3'b000) begin tests_failed++; $display("FAIL b2b_outs%0d got %b want 000", i, {branch_taken, pc_load, flush}); end
      tests_run++; if (pc_target !== 32'h100) begin tests_failed++; $display("FAIL b2b_hold%0d got %h want 100", i, pc_target); end
    end
    bus.br_valid = 1'b0;
  endtask

  task automatic test_forwarding();
    flags_q = 6'b000000; fl_in = 6'b000010; fl_write_enable = 1'b1;
    bus.br_cond = 3'd1; bus.br_jt = 1'b1; bus.br_target = 32'h200; bus.br_valid = 1'b1;
    step();
    bus.br_valid = 1'b0; fl_write_enable = 1'b0;
    tests_run++; if (branch_taken !== 1'b1) begin tests_failed++; $display("FAIL fwd_taken got %b want 1", branch_taken); end
    tests_run++; if (pc_target !== 32'h200) begin tests_failed++; $display("FAIL fwd_target got %h want 200", pc_target); end
    step();
    step();
  endtask

  task automatic test_pending_stall();
    flags_q = 6'b000001; flags_pending = 1'b1;
    bus.br_cond = 3'd0; bus.br_jt = 1'b1; bus.br_target = 32'h300; bus.br_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++; if (bus.br_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_ready%0d got %b want 0", i, bus.br_ready); end
      step();
      tests_run++; if (branch_taken !== 1'b0) begin tests_failed++; $display("FAIL stall_taken%0d got %b want 0", i, branch_taken); end
    end
    flags_pending = 1'b0;
    #1;
    tests_run++; if (bus.br_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_release got %b want 1", bus.br_ready); end
    step();
    bus.br_valid = 1'b0;
    tests_run++; if ({branch_taken, pc_load} !== 2'b11) begin tests_failed++; $display("FAIL stall_taken got %b want 11", {branch_taken, pc_load}); end
    tests_run++; if (pc_target !== 32'h300) begin tests_failed++; $display("FAIL stall_target got %h want 300", pc_target); end
    step();
    step();
  endtask

  task automatic test_illegal_cond();
    flags_q = 6'b111111; bus.br_cond = 3'd7; bus.br_jt = 1'b1; bus.br_target = 32'h700; bus.br_valid = 1'b1;
    step();
    bus.br_valid = 1'b0;
    tests_run++; if (cond_error !== 1'b1) begin tests_failed++; $display("FAIL ill_err got %b want 1", cond_error); end
    tests_run++; if ({branch_taken, flush} !== 2'b00) begin tests_failed++; $display("FAIL ill_noflush got %b want 00", {branch_taken, flush}); end
    tests_run++; if (bus.br_ready !== 1'b1) begin tests_failed++; $display("FAIL ill_ready got %b want 1", bus.br_ready); end
    step();
    tests_run++; if (cond_error !== 1'b0) begin tests_failed++; $display("FAIL ill_pulse got %b want 0", cond_error); end
  endtask

  task automatic test_reset_mid_flush();
    flags_q = 6'b000001; bus.br_cond = 3'd0; bus.br_jt = 1'b1; bus.br_target = 32'h400; bus.br_valid = 1'b1;
    step();
    bus.br_valid = 1'b0;
    step();
    tests_run++; if (flush !== 1'b1) begin tests_failed++; $display("FAIL mid_flush_pre got %b want 1", flush); end
    #2;
    rst = 1'b0;
    #1;
    tests_run++; if ({branch_taken, pc_load, flush, cond_error} !== 4'b0000) begin tests_failed++; $display("FAIL mid_rst_outs got %b want 0000", {branch_taken, pc_load, flush, cond_error}); end
    tests_run++; if (pc_target !== 32'h0) begin tests_failed++; $display("FAIL mid_rst_target got %h want 0", pc_target); end
    tests_run++; if (bus.br_ready !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_ready got %b want 0", bus.br_ready); end
    step();
    rst = 1'b1;
    #1;
    tests_run++; if (bus.br_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_rel_ready got %b want 1", bus.br_ready); end
    step();
    tests_run++; if (flush !== 1'b0) begin tests_failed++; $display("FAIL mid_rel_flush got %b want 0", flush); end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b0; flags_q = '0; fl_in = '0; fl_write_enable = 1'b0; flags_pending = 1'b0;
    bus.br_valid = 1'b0; bus.br_cond = '0; bus.br_jt = 1'b0; bus.br_target = '0;
    #1;
    test_reset();
    test_jt_zero_taken();
    test_back_to_back();
    test_forwarding();
    test_pending_stall();
    test_illegal_cond();
    test_reset_mid_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
